// File: rtl/cc_row_shifter_pkg.sv
// Shared definitions for the row shifter: FSM state codes, default geometry
// and rotate direction codes.
package cc_row_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    HIT   = 2'b11
  } rowState_t;

  localparam int          DEFAULT_DATAWIDTH = 8;
  localparam int          DEFAULT_TICKS     = 4;
  localparam logic [7:0]  DEFAULT_INIT      = 8'b00000001;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/cc_row_shifter_tick.sv
// Tick prescaler: counts enabled cycles and flags the terminal count, after
// which it wraps to zero on its own.
module cc_tick_prescaler #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic countEn,
  output logic terminal
);

  localparam int CW = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  assign terminal = countEn && (count == LAST);

  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      count <= '0;
    end else if (countEn) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cc_row_shifter.sv
// Rotating row register with a run/pause/hit FSM; the row is rotated once per
// prescaler period and frozen when the downstream nest checker reports a match.
module cc_row_shifter
  import cc_row_shifter_pkg::*;
#(
  parameter int ROWSHIFTER_DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ROWSHIFTER_TICKS     = DEFAULT_TICKS,
  parameter logic [ROWSHIFTER_DATAWIDTH-1:0] ROWSHIFTER_INIT =
    ROWSHIFTER_DATAWIDTH'(DEFAULT_INIT)
) (
  input  logic                            CC_ROW_SHIFTER_CLOCK_50,
  input  logic                            CC_ROW_SHIFTER_RESET_InLow,
  input  logic                            CC_ROW_SHIFTER_load_InLow,
  input  logic [ROWSHIFTER_DATAWIDTH-1:0] CC_ROW_SHIFTER_data_InBUS,
  input  logic                            CC_ROW_SHIFTER_dir_In,
  input  logic                            CC_ROW_SHIFTER_enable_In,
  input  logic                            CC_ROW_SHIFTER_nest_InLow,
  output logic [ROWSHIFTER_DATAWIDTH-1:0] CC_ROW_SHIFTER_data_OutBUS,
  output logic                            CC_ROW_SHIFTER_step_Out,
  output logic                            CC_ROW_SHIFTER_hit_Out,
  output logic [1:0]                      CC_ROW_SHIFTER_state_OutBUS
);

  localparam int W = ROWSHIFTER_DATAWIDTH;

  logic            clk;
  logic            resetN;
  logic            loadN;
  logic            nestN;
  rowState_t       state;
  rowState_t       nextState;
  logic [W-1:0]    row;
  logic [W-1:0]    rotated;
  logic            stepReg;
  logic            hitReg;
  logic            countEn;
  logic            shiftNow;

  assign clk    = CC_ROW_SHIFTER_CLOCK_50;
  assign resetN = CC_ROW_SHIFTER_RESET_InLow;
  assign loadN  = CC_ROW_SHIFTER_load_InLow;
  assign nestN  = CC_ROW_SHIFTER_nest_InLow;

  // Counting only happens in a RUN cycle that stays in RUN; a load or a match wins over a tick.
  assign countEn = (state == RUN) && CC_ROW_SHIFTER_enable_In && nestN && loadN;

  cc_tick_prescaler #(
    .TICKS(ROWSHIFTER_TICKS)
  ) uPrescaler (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (!loadN),
    .countEn (countEn),
    .terminal(shiftNow)
  );

  assign rotated = (CC_ROW_SHIFTER_dir_In == DIR_LEFT) ? {row[W-2:0], row[W-1]}
                                                       : {row[0], row[W-1:1]};

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (!loadN) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:  if (CC_ROW_SHIFTER_enable_In) nextState = RUN;
        RUN: begin
          if (!nestN)                         nextState = HIT;
          else if (!CC_ROW_SHIFTER_enable_In) nextState = PAUSE;
        end
        PAUSE: begin
          if (!nestN)                        nextState = HIT;
          else if (CC_ROW_SHIFTER_enable_In) nextState = RUN;
        end
        HIT:     nextState = HIT;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      row     <= ROWSHIFTER_INIT;
      stepReg <= 1'b0;
      hitReg  <= 1'b0;
    end else if (!loadN) begin
      row     <= CC_ROW_SHIFTER_data_InBUS;
      stepReg <= 1'b0;
      hitReg  <= 1'b0;
    end else begin
      stepReg <= shiftNow;
      if (shiftNow) begin
        row <= rotated;
      end
      if ((state == RUN || state == PAUSE) && !nestN) begin
        hitReg <= 1'b1;
      end
    end
  end

  assign CC_ROW_SHIFTER_data_OutBUS  = row;
  assign CC_ROW_SHIFTER_step_Out     = stepReg;
  assign CC_ROW_SHIFTER_hit_Out      = hitReg;
  assign CC_ROW_SHIFTER_state_OutBUS = state;

endmodule
